axi4_lite_rd_arb: RTL and testbench
===================================

// Module: axi4_lite_rd_arb
// PURPOSE
//   Shares one AXI4-Lite read master channel between NUM_REQ user requesters.
//   Round-robin arbitration; one outstanding transaction at a time.
//   Sits between user logic (register pollers, status readers) and the
//   AXI4-Lite slave. Returns read data and RRESP to the granted requester only.
//   Keeps a saturating count of non-OKAY responses.
// PARAMETERS
//   NUM_REQ    4   number of requesters, 2..8
//   ID_W       2   grant index width, = clog2(NUM_REQ)
//   ERR_CNT_W  16  width of the error counter
// PORTS
//   clk            in   1            clock, all logic on rising edge
//   arst           in   1            reset, asynchronous, active-high
//   req_addr       in   NUM_REQ*32   requester i address in bits [32*i+31:32*i]
//   req_valid      in   NUM_REQ      requester i read request
//   req_ready      out  NUM_REQ      one-cycle completion pulse to requester i
//   req_data       out  32           read data, valid only while any req_ready bit is 1
//   req_resp       out  2            RRESP, valid only while any req_ready bit is 1
//   grant_id       out  ID_W         index of current/last granted requester
//   busy           out  1            1 in any state other than IDLE
//   err_cnt        out  ERR_CNT_W    count of RRESP != 2'b00, saturating
//   s_axi_araddr   out  32           AR address
//   s_axi_arvalid  out  1            AR valid
//   s_axi_arready  in   1            AR ready
//   s_axi_rdata    in   32           R data
//   s_axi_rresp    in   2            R response
//   s_axi_rvalid   in   1            R valid
//   s_axi_rready   out  1            R ready
// BEHAVIOUR
//   Reset values
//     - All outputs 0. FSM = IDLE. last_grant = NUM_REQ-1, so requester 0 has
//       top priority first. err_cnt = 0.
//     - Reset mid-transaction abandons it immediately. No completion pulse.
//   FSM (one-hot): IDLE -> ADDR -> DATA -> RESP -> IDLE
//     - IDLE: if req_valid != 0, choose the winner.
//         Search starts at (last_grant+1) mod NUM_REQ and wraps upward.
//         Latch winner index into grant_id and req_addr[winner] into addr_q.
//         Go to ADDR.
//     - ADDR: s_axi_arvalid=1, s_axi_araddr=addr_q.
//         Hold both until s_axi_arready=1, then go to DATA.
//     - DATA: s_axi_rready=1.
//         On s_axi_rvalid=1, capture rdata and rresp, then go to RESP.
//     - RESP: req_ready[grant_id]=1 for exactly one cycle.
//         req_data and req_resp present the captured values.
//         Set last_grant=grant_id. If resp != 0, increment err_cnt unless it is
//         at all-ones. Go to IDLE.
//   Output gating
//     - s_axi_araddr = 0 outside ADDR.
//     - req_data and req_resp = 0 outside RESP.
//   Rules
//     - Request sampling:
//         A requester holds req_valid until it sees its req_ready pulse.
//         Its address is sampled only at grant; later changes are ignored.
//         A valid dropped before grant is simply not considered.
//     - Minimum latency, with arready and rvalid high on first sight:
//         valid seen in IDLE at cycle 0, ADDR at 1, DATA at 2, req_ready at 3.
//     - Back-to-back grants: one IDLE cycle between transactions.
//         The requester just served is lowest priority in that arbitration.
//     - Independence: arready and rvalid are taken independently. rvalid while
//         in ADDR is ignored, since AXI ordering guarantees it cannot occur.
//     - Requester changes: req_valid changes during ADDR, DATA or RESP do not
//         affect the transaction in flight.
//     - Unused encodings: unused one-hot states recover to IDLE.
// TESTING
//   1. Reset only -> all outputs 0.
//      First request from req 2, addr 0x40 -> araddr=0x40, grant_id=2.
//   2. Single req 0, addr 0x10; arready and rvalid immediate; rdata=0xDEADBEEF,
//      rresp=0 -> req_ready[0] pulses at cycle 3 with req_data=0xDEADBEEF,
//      err_cnt stays 0.
//   3. All 4 valid and held -> grant order 0,1,2,3,0.
//      Each req_ready is a single-cycle pulse; one IDLE cycle between grants.
//   4. arready delayed 5 cycles, rvalid delayed 7 -> arvalid and araddr stay
//      stable throughout. rready is high only in DATA. Exactly one completion.
//   5. rresp=2'b10 on 3 reads -> req_resp=2'b10 on each, err_cnt=3.
//      Preload err_cnt to all-ones -> it stays at all-ones.
//   6. arst asserted while in DATA -> outputs 0 in the same cycle, no req_ready.
//      After release, the next grant goes to req 0.

Source files
------------

// File: rtl/axi4_lite_rd_arb_if.sv
// AXI4-Lite read-channel bundle (AR + R) shared between the arbiter and the slave.
// The master side drives the address and R-ready; the slave side answers.
interface axi4_lite_rd_arb_if;

    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output araddr,
        output arvalid,
        output rready,
        input  arready,
        input  rdata,
        input  rresp,
        input  rvalid
    );

    modport slave (
        input  araddr,
        input  arvalid,
        input  rready,
        output arready,
        output rdata,
        output rresp,
        output rvalid
    );

endinterface

// File: rtl/axi4_lite_rd_arb.sv
// AXI4-Lite read arbiter: shares one read master channel between NUM_REQ
// requesters with round-robin priority and a single outstanding transaction.
// Read data and response go back only to the granted requester as a one-cycle
// completion pulse. Non-OKAY responses are counted in a saturating counter.
// Every output is driven straight from a flop so an asynchronous reset clears
// the whole interface in the same cycle it is asserted.
module axi4_lite_rd_arb #(
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 2,
    parameter int ERR_CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic [NUM_REQ*32-1:0]     req_addr,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [31:0]               req_data,
    output logic [1:0]                req_resp,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy,
    output logic [ERR_CNT_W-1:0]      err_cnt,
    axi4_lite_rd_arb_if.master        s_axi
);

    // One-hot transaction phases; any other encoding falls back to IDLE.
    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_ADDR = 4'b0010,
        ST_DATA = 4'b0100,
        ST_RESP = 4'b1000
    } state_t;

    localparam logic [ID_W-1:0]      LAST_RST = ID_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0]   ONE_REQ  = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0] ERR_ONE  = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    // Round-robin pick: scan upward starting just after the last winner,
    // wrapping modulo NUM_REQ, and take the first active request.
    function automatic logic [ID_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] valid,
        input logic [ID_W-1:0]    last
    );
        logic [ID_W-1:0] pick;
        logic [ID_W-1:0] idx;
        logic            found;
        logic            hit;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx   = ID_W'((int'(last) + k) % NUM_REQ);
            hit   = !found && valid[idx];
            pick  = hit ? idx : pick;
            found = found | hit;
        end
        return pick;
    endfunction

    state_t                state_r,      state_s;
    logic [ID_W-1:0]       last_grant_r, last_grant_s;
    logic [ID_W-1:0]       grant_id_r,   grant_id_s;
    logic [ERR_CNT_W-1:0]  err_cnt_r,    err_cnt_s;
    logic [31:0]           araddr_r,     araddr_s;
    logic                  arvalid_r,    arvalid_s;
    logic                  rready_r,     rready_s;
    logic [NUM_REQ-1:0]    req_ready_r,  req_ready_s;
    logic [31:0]           req_data_r,   req_data_s;
    logic [1:0]            req_resp_r,   req_resp_s;
    logic                  busy_r,       busy_s;

    logic [ID_W-1:0]       winner_s;
    logic [31:0]           winner_addr_s;

    // Arbitration winner for the current request vector.
    always_comb begin
        winner_s = rr_pick(req_valid, last_grant_r);
    end

    // Address of the winning requester, sampled only when the grant is taken.
    always_comb begin
        winner_addr_s = 32'h0000_0000;
        for (int i = 0; i < NUM_REQ; i++) begin
            winner_addr_s = (winner_s == ID_W'(i)) ? req_addr[32*i +: 32] : winner_addr_s;
        end
    end

    // Next-state and next-output decode; pulses and gated buses default to 0.
    always_comb begin
        state_s      = state_r;
        last_grant_s = last_grant_r;
        grant_id_s   = grant_id_r;
        err_cnt_s    = err_cnt_r;
        araddr_s     = 32'h0000_0000;
        arvalid_s    = 1'b0;
        rready_s     = 1'b0;
        req_ready_s  = {NUM_REQ{1'b0}};
        req_data_s   = 32'h0000_0000;
        req_resp_s   = 2'b00;
        busy_s       = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (req_valid != {NUM_REQ{1'b0}}) begin
                    state_s    = ST_ADDR;
                    grant_id_s = winner_s;
                    araddr_s   = winner_addr_s;
                    arvalid_s  = 1'b1;
                    busy_s     = 1'b1;
                end else begin
                    state_s    = ST_IDLE;
                end
            end

            ST_ADDR: begin
                busy_s = 1'b1;
                if (s_axi.arready) begin
                    // Address accepted: drop AR and open the R channel.
                    state_s  = ST_DATA;
                    rready_s = 1'b1;
                end else begin
                    // Hold address and valid stable until accepted.
                    state_s   = ST_ADDR;
                    araddr_s  = araddr_r;
                    arvalid_s = 1'b1;
                end
            end

            ST_DATA: begin
                busy_s = 1'b1;
                if (s_axi.rvalid) begin
                    state_s     = ST_RESP;
                    req_ready_s = ONE_REQ << grant_id_r;
                    req_data_s  = s_axi.rdata;
                    req_resp_s  = s_axi.rresp;
                end else begin
                    state_s  = ST_DATA;
                    rready_s = 1'b1;
                end
            end

            ST_RESP: begin
                // Completion pulse is on the outputs this cycle; retire it.
                state_s      = ST_IDLE;
                last_grant_s = grant_id_r;
                if ((req_resp_r != 2'b00) && (err_cnt_r != ERR_MAX)) begin
                    err_cnt_s = err_cnt_r + ERR_ONE;
                end else begin
                    err_cnt_s = err_cnt_r;
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_r      <= ST_IDLE;
            last_grant_r <= LAST_RST;
            grant_id_r   <= {ID_W{1'b0}};
            err_cnt_r    <= {ERR_CNT_W{1'b0}};
            araddr_r     <= 32'h0000_0000;
            arvalid_r    <= 1'b0;
            rready_r     <= 1'b0;
            req_ready_r  <= {NUM_REQ{1'b0}};
            req_data_r   <= 32'h0000_0000;
            req_resp_r   <= 2'b00;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            last_grant_r <= last_grant_s;
            grant_id_r   <= grant_id_s;
            err_cnt_r    <= err_cnt_s;
            araddr_r     <= araddr_s;
            arvalid_r    <= arvalid_s;
            rready_r     <= rready_s;
            req_ready_r  <= req_ready_s;
            req_data_r   <= req_data_s;
            req_resp_r   <= req_resp_s;
            busy_r       <= busy_s;
        end
    end

    assign s_axi.araddr  = araddr_r;
    assign s_axi.arvalid = arvalid_r;
    assign s_axi.rready  = rready_r;
    assign req_ready     = req_ready_r;
    assign req_data      = req_data_r;
    assign req_resp      = req_resp_r;
    assign grant_id      = grant_id_r;
    assign busy          = busy_r;
    assign err_cnt       = err_cnt_r;

endmodule

// File: tb/tb_axi4_lite_rd_arb.sv
// Testbench for axi4_lite_rd_arb: scoreboard of expected completions, a
// delay-programmable AXI4-Lite slave model and directed scenarios.
module tb_axi4_lite_rd_arb;

    localparam int NUM_REQ   = 4;
    localparam int ID_W      = 2;
    localparam int ERR_CNT_W = 3;

    logic                   clk;
    logic                   arst;
    logic [NUM_REQ*32-1:0]  req_addr;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [31:0]            req_data;
    logic [1:0]             req_resp;
    logic [ID_W-1:0]        grant_id;
    logic                   busy;
    logic [ERR_CNT_W-1:0]   err_cnt;

    axi4_lite_rd_arb_if bus();

    axi4_lite_rd_arb #(
        .NUM_REQ   (NUM_REQ),
        .ID_W      (ID_W),
        .ERR_CNT_W (ERR_CNT_W)
    ) dut (
        .clk       (clk),
        .arst      (arst),
        .req_addr  (req_addr),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_resp  (req_resp),
        .grant_id  (grant_id),
        .busy      (busy),
        .err_cnt   (err_cnt),
        .s_axi     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          ar_delay = 0;
    int          r_delay = 0;
    logic [1:0]  resp_mode = 2'b00;
    logic [NUM_REQ-1:0] prev_ready = '0;

    // Slave memory contents: a fixed function of the address.
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hDEAD_BEFF;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int idx, input logic [31:0] addr, input logic [1:0] resp);
        exp_t e;
        e.idx  = idx;
        e.addr = addr;
        e.data = mem_data(addr);
        e.resp = resp;
        exp_q.push_back(e);
    endtask

    task automatic set_req(input int idx, input logic [31:0] addr);
        req_addr[32*idx +: 32] = addr;
        req_valid[idx] = 1'b1;
        push_exp(idx, addr, resp_mode);
    endtask

    task automatic do_reset();
        arst = 1'b1;
        req_valid = '0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
    endtask

    // Wait for n completions; optionally each requester drops on its pulse.
    task automatic wait_done(input string tag, input int n, input int budget,
                             input bit drop, output int cyc);
        int got;
        got = 0;
        cyc = 0;
        while (got < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (req_ready != '0) begin
                got++;
                if (drop) req_valid = req_valid & ~req_ready;
            end
        end
        check_eq({"done_", tag}, got, n);
    endtask

    task automatic serve(input string tag, input int idx, input logic [31:0] addr);
        int cyc;
        set_req(idx, addr);
        wait_done(tag, 1, 40, 1'b1, cyc);
        @(negedge clk);
    endtask

    // Slave model: AR and R acceptance after programmable wait cycles.
    initial begin : slave
        int          ar_cnt;
        int          r_cnt;
        logic [31:0] lat_addr;
        ar_cnt = 0;
        r_cnt = 0;
        lat_addr = 32'h0;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rdata   = 32'h0;
        bus.rresp   = 2'b00;
        forever begin
            @(negedge clk);
            if (arst) begin
                ar_cnt = 0;
                r_cnt = 0;
                bus.arready = 1'b0;
                bus.rvalid  = 1'b0;
                bus.rdata   = 32'h0;
                bus.rresp   = 2'b00;
            end else begin
                if (bus.arvalid && !bus.arready) begin
                    lat_addr = bus.araddr;
                    if (ar_cnt == ar_delay) bus.arready = 1'b1;
                    else ar_cnt++;
                end else begin
                    bus.arready = 1'b0;
                    ar_cnt = 0;
                end
                if (bus.rready && !bus.rvalid) begin
                    if (r_cnt == r_delay) begin
                        bus.rvalid = 1'b1;
                        bus.rdata  = mem_data(lat_addr);
                        bus.rresp  = resp_mode;
                    end else begin
                        r_cnt++;
                    end
                end else begin
                    bus.rvalid = 1'b0;
                    bus.rdata  = 32'h0;
                    bus.rresp  = 2'b00;
                    r_cnt = 0;
                end
            end
        end
    end

    // Monitor: address/grant against scoreboard front, completions popped.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (arst) begin
                prev_ready = '0;
            end else begin
                if (bus.arvalid) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_ar", 1, 0);
                    end else begin
                        check_eq("araddr", bus.araddr, exp_q[0].addr);
                        check_eq("grant_id", grant_id, exp_q[0].idx);
                    end
                    check_eq("rready_in_addr", bus.rready, 0);
                end else begin
                    check_eq("araddr_gated", bus.araddr, 0);
                end
                if (req_ready != '0) begin
                    check_eq("pulse_width", prev_ready, 0);
                    check_eq("rready_in_resp", bus.rready, 0);
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_completion", req_ready, 0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check_eq("req_ready", req_ready, 64'd1 << mon_e.idx);
                        check_eq("req_data", req_data, mon_e.data);
                        check_eq("req_resp", req_resp, mon_e.resp);
                    end
                end else begin
                    check_eq("data_gated", {req_data, req_resp}, 0);
                end
                if (prev_ready != '0) check_eq("idle_gap", busy, 0);
                prev_ready = req_ready;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : stimulus
        int cyc;
        int lat;
        int n_ar;
        int n_r;
        int pulses;
        arst = 1'b1;
        req_valid = '0;
        req_addr = '0;

        // 1: reset state, first request from req 2
        do_reset();
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_req_data", req_data, 0);
        check_eq("rst_misc", {req_resp, grant_id, busy, err_cnt, bus.arvalid, bus.rready}, 0);
        check_eq("rst_araddr", bus.araddr, 0);
        set_req(2, 32'h40);
        @(negedge clk);
        check_eq("t1_araddr", bus.araddr, 32'h40);
        check_eq("t1_grant", grant_id, 2);
        check_eq("t1_busy", busy, 1);
        wait_done("t1", 1, 20, 1'b1, cyc);

        // 2: minimum latency, DEADBEEF
        repeat (2) @(negedge clk);
        set_req(0, 32'h10);
        lat = 0;
        while (req_ready == '0 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_eq("t2_latency", lat, 3);
        check_eq("t2_req_ready", req_ready, 4'b0001);
        check_eq("t2_data", req_data, 32'hDEADBEEF);
        req_valid = req_valid & ~req_ready;
        @(negedge clk);
        check_eq("t2_err_cnt", err_cnt, 0);

        // 3: all held -> 0,1,2,3,0 with one idle cycle between grants
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'h100 + 32'(16 * i));
        push_exp(0, 32'h100, 2'b00);
        wait_done("t3", 5, 60, 1'b0, cyc);
        req_valid = '0;
        check_eq("t3_cycles", cyc, 19);
        repeat (4) @(negedge clk);

        // 4: delayed arready / rvalid
        ar_delay = 5;
        r_delay = 7;
        set_req(1, 32'h2000);
        n_ar = 0;
        n_r = 0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.arvalid) n_ar++;
            if (bus.rready) n_r++;
            if (req_ready != '0) begin
                pulses++;
                req_valid = req_valid & ~req_ready;
            end
        end
        check_eq("t4_arvalid_cycles", n_ar, 6);
        check_eq("t4_rready_cycles", n_r, 8);
        check_eq("t4_completions", pulses, 1);
        ar_delay = 0;
        r_delay = 0;

        // 5: error responses and saturation (counter width 3 -> max 7)
        resp_mode = 2'b10;
        for (int k = 0; k < 3; k++) serve("t5a", 3, 32'h300 + 32'(4 * k));
        check_eq("t5_err3", err_cnt, 3);
        resp_mode = 2'b11;
        for (int k = 0; k < 4; k++) serve("t5b", k, 32'h400 + 32'(4 * k));
        check_eq("t5_err7", err_cnt, 7);
        resp_mode = 2'b01;
        for (int k = 0; k < 2; k++) serve("t5c", 2, 32'h500 + 32'(4 * k));
        check_eq("t5_sat", err_cnt, 7);
        resp_mode = 2'b00;
        serve("t5d", 1, 32'h600);
        check_eq("t5_okay_keeps", err_cnt, 7);

        // 6: reset while in DATA
        r_delay = 20;
        set_req(2, 32'h80);
        lat = 0;
        while (!bus.rready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_eq("t6_in_data", bus.rready, 1);
        @(negedge clk);
        arst = 1'b1;
        #1;
        check_eq("t6_req_ready", req_ready, 0);
        check_eq("t6_misc", {busy, bus.arvalid, bus.rready, grant_id, req_resp}, 0);
        check_eq("t6_araddr", bus.araddr, 0);
        check_eq("t6_err_cnt", err_cnt, 0);
        check_eq("t6_data", req_data, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        arst = 1'b0;
        r_delay = 0;
        set_req(0, 32'h0C);
        push_exp(2, 32'h80, 2'b00);
        wait_done("t6", 2, 40, 1'b1, cyc);

        repeat (3) @(negedge clk);
        check_eq("exp_q_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
